// File: rtl/spi_reg_bank.sv
// Serial register bank: frames of R/W bit, address and burst data words write or read
// NUM_CH channel registers, all clocked by the serial clock.
module spi_reg_bank #(
   parameter int unsigned NUM_CH = 8,
   parameter int unsigned REG_W  = 8,
   parameter int unsigned ADDR_W = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cs_n,
   input  logic                    serial_in,
   output logic                    serial_out,
   output logic [NUM_CH*REG_W-1:0] ch_out,
   output logic                    wr_strobe,
   output logic [ADDR_W-1:0]       wr_addr,
   output logic                    addr_err
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StCmd  = 2'd1;
   localparam logic [1:0] StData = 2'd2;

   localparam int unsigned       MaxCnt   = (REG_W > ADDR_W) ? REG_W : ADDR_W;
   localparam int unsigned       CntW     = $clog2(MaxCnt + 1);
   localparam logic [CntW-1:0]   AddrLast = CntW'(ADDR_W - 1);
   localparam logic [CntW-1:0]   BitLast  = CntW'(REG_W - 1);
   localparam logic [ADDR_W-1:0] ChLast   = ADDR_W'(NUM_CH - 1);

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return 32'(a) < NUM_CH;
   endfunction

   // Out-of-range addresses match no channel and therefore read as zero.
   function automatic logic [REG_W-1:0] pick(input logic [NUM_CH*REG_W-1:0] bank,
                                             input logic [ADDR_W-1:0]       a);
      logic [REG_W-1:0] w;
      w = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (a == ADDR_W'(k)) w = bank[k*REG_W +: REG_W];
      end
      return w;
   endfunction

   logic [1:0]              state_q, state_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic                    rw_q, rw_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [REG_W-1:0]        word_q, word_d;
   logic [REG_W-1:0]        rd_q, rd_d;
   logic                    so_q, so_d;
   logic [NUM_CH*REG_W-1:0] ch_q, ch_d;
   logic                    stb_q, stb_d;
   logic [ADDR_W-1:0]       wa_q, wa_d;
   logic                    err_q, err_d;

   logic [ADDR_W-1:0]       addr_new, addr_inc;
   logic [REG_W-1:0]        word_new, rd_sel;

   assign addr_new = (addr_q << 1) | ADDR_W'(serial_in);
   assign word_new = (word_q << 1) | REG_W'(serial_in);
   assign addr_inc = (addr_q == ChLast) ? '0 : addr_q + ADDR_W'(1);
   assign rd_sel   = pick(ch_q, (state_q == StCmd) ? addr_new : addr_inc);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      word_d  = word_q;
      rd_d    = rd_q;
      so_d    = 1'b0;
      ch_d    = ch_q;
      stb_d   = 1'b0;
      wa_d    = wa_q;
      err_d   = err_q;

      if (cs_n) begin
         // Frame boundary: drop any partial word and return to idle.
         state_d = StIdle;
         cnt_d   = '0;
         word_d  = '0;
         rd_d    = '0;
      end else begin
         case (state_q)
            StIdle: begin
               rw_d    = serial_in;
               addr_d  = '0;
               cnt_d   = '0;
               word_d  = '0;
               state_d = StCmd;
            end
            StCmd: begin
               addr_d = addr_new;
               if (cnt_q == AddrLast) begin
                  state_d = StData;
                  cnt_d   = '0;
                  if (!in_range(addr_new)) err_d = 1'b1;
                  if (!rw_q) begin
                     so_d = rd_sel[REG_W-1];
                     rd_d = rd_sel << 1;
                  end
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StData: begin
               word_d = word_new;
               if (cnt_q == BitLast) begin
                  cnt_d  = '0;
                  word_d = '0;
                  addr_d = addr_inc;
                  if (!in_range(addr_inc)) err_d = 1'b1;
                  if (rw_q) begin
                     if (in_range(addr_q)) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                           if (addr_q == ADDR_W'(k)) ch_d[k*REG_W +: REG_W] = word_new;
                        end
                        stb_d = 1'b1;
                        wa_d  = addr_q;
                     end
                  end else begin
                     so_d = rd_sel[REG_W-1];
                     rd_d = rd_sel << 1;
                  end
               end else begin
                  cnt_d = cnt_q + CntW'(1);
                  if (!rw_q) begin
                     so_d = rd_q[REG_W-1];
                     rd_d = rd_q << 1;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         word_q  <= '0;
         rd_q    <= '0;
         so_q    <= 1'b0;
         ch_q    <= '0;
         stb_q   <= 1'b0;
         wa_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
         rd_q    <= rd_d;
         so_q    <= so_d;
         ch_q    <= ch_d;
         stb_q   <= stb_d;
         wa_q    <= wa_d;
         err_q   <= err_d;
      end
   end

   assign serial_out = so_q;
   assign ch_out     = ch_q;
   assign wr_strobe  = stb_q;
   assign wr_addr    = wa_q;
   assign addr_err   = err_q;

endmodule
